accum_deskew: RTL and testbench
===============================

ACCUM_DESKEW -- requirements
Module: accum_deskew

Interface
REQ-001 Parameter OC0, default 4: number of array columns (partial-sum lanes), at least 2.
REQ-002 Parameter DEPTH, default 8: output FIFO depth in aligned words, a power of 2 and at least OC0.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 en  input  1  array-advance enable; the deskew pipeline shifts only when high.
REQ-006 clr  input  1  synchronous flush of the pipeline, FIFO and overflow flag.
REQ-007 col0_valid  input  1  column 0 of accum_out_chained carries a valid partial sum this cycle.
REQ-008 accum_out_chained  input  32*OC0  bottom-row partial sums; lane j is bits [32j+31:32j], signed.
REQ-009 out_dat  output  32*OC0  aligned output word, same lane packing.
REQ-010 out_valid  output  1  out_dat holds a valid word.
REQ-011 out_ready  input  1  consumer accepts out_dat when out_valid and out_ready are both high.
REQ-012 fifo_room  output  1  high when FIFO count <= DEPTH-OC0; the array controller drops en while it is low.
REQ-013 overflow  output  1  sticky flag: an aligned word was dropped.

Function
REQ-014 Lane j SHALL be delayed by OC0-1-j en-qualified register stages; lane OC0-1 feeds the FIFO write port with no register stage.
REQ-015 col0_valid SHALL pass through an OC0-1 stage en-qualified valid shift chain; its last stage is the push request.
REQ-016 When en is low, no delay stage or valid stage SHALL change, and no push SHALL occur.
REQ-017 With en held high, col0_valid=1 in cycle k SHALL cause a push at the edge ending cycle k+OC0-1; that word holds lane j sampled in cycle k+j.
REQ-018 The pushed word SHALL appear on out_dat with out_valid=1 starting in cycle k+OC0; an empty FIFO has no bypass path.
REQ-019 Lane data SHALL pass bit-exact (signed 32-bit), with no arithmetic, saturation or reordering.
REQ-020 The FIFO SHALL be first-word-fall-through: out_dat = entry at the read pointer, and out_valid = (count != 0).
REQ-021 A pop SHALL occur on an edge where out_valid and out_ready are both high; out_dat SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when the FIFO is full.
REQ-024 A push with count=DEPTH and no same-cycle pop SHALL be discarded and SHALL set overflow; FIFO contents are unchanged.
REQ-025 overflow SHALL stay set until clr or reset.
REQ-026 clr SHALL take priority over en, push and pop, and SHALL zero all valid stages, pointers, count and overflow; delay data need not be cleared.
REQ-027 fifo_room SHALL be combinational from count.

Reset
REQ-028 On rst_n low, regardless of clk: valid chain, pointers and count SHALL be 0, out_valid=0, overflow=0, fifo_room=1, and out_dat=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight and queued words; no push SHALL occur in the first cycle after release.

Structure
REQ-030 Shared package accum_pkg SHALL hold ACC_W=32, DAT_W=16 and the default OC0 and IC0 used by the array and this block.
REQ-031 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty); delay chains stay inside accum_deskew.

Verification
REQ-032 Skewed input: OC0=4, en=1, out_ready=1, col0_valid=1 in cycle 10, lane j = 100+j in cycle 10+j -> out_valid in cycle 14 with out_dat lanes {100,101,102,103}.
REQ-033 Signed data: lane values -1, -32768, 0x7FFFFFFF, 0x80000000 -> same bit patterns on out_dat.
REQ-034 Stall: en=0 for 3 cycles between lane 1 and lane 2 arrival -> the aligned word is still correct, and out_valid is delayed by exactly 3 cycles.
REQ-035 Backpressure: out_ready=0, 9 rows pushed with DEPTH=8 -> fifo_room falls at count 5, overflow sets on the 9th push, and the first 8 words drain in order once out_ready=1.
REQ-036 Full with simultaneous push and pop: count stays 8, overflow stays 0, and order is preserved.
REQ-037 Reset or clr with 3 words queued and 2 in flight -> out_valid=0 the next cycle, and the next output is the first row launched after release.

Source files
------------

// File: rtl/accum_pkg.sv
// Widths and default array geometry shared by the systolic array and its
// output deskew.
package accum_pkg;
   localparam int ACC_W       = 32;
   localparam int DAT_W       = 16;
   localparam int OC0_DEFAULT = 4;
   localparam int IC0_DEFAULT = 4;

   typedef logic signed [ACC_W-1:0] acc_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO. A push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // When full, push and pop share the head slot: the old entry leaves as the new one lands.
   always_ff @(posedge clk) begin
      if (do_push && !clr) begin
         mem[wr_ptr] <= din;
      end
   end

   assign dout = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/accum_deskew.sv
// Realigns the diagonally skewed bottom-row partial sums of the array into
// whole words and queues them for a ready/valid consumer.
module accum_deskew
   import accum_pkg::*;
#(
   parameter int OC0   = OC0_DEFAULT,
   parameter int DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 clr,
   input  logic                 col0_valid,
   input  logic [ACC_W*OC0-1:0] accum_out_chained,
   output logic [ACC_W*OC0-1:0] out_dat,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 fifo_room,
   output logic                 overflow
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int VLD_N = OC0 - 1;
   localparam logic [CNT_W-1:0] ROOM_MAX = CNT_W'(DEPTH - OC0);

   logic [VLD_N-1:0]     vld_p;
   logic [ACC_W*OC0-1:0] word_p;
   logic                 push;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic [CNT_W-1:0]     count;

   // Valid chain: the last stage marks the cycle where every lane is aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
      end else if (clr) begin
         vld_p <= '0;
      end else if (en) begin
         vld_p[0] <= col0_valid;
         for (int s = 1; s < VLD_N; s++) begin
            vld_p[s] <= vld_p[s-1];
         end
      end
   end

   // Lane j arrives j advances late, so it waits OC0-1-j advances to line up.
   for (genvar j = 0; j < OC0; j++) begin : g_lane
      if (j == OC0 - 1) begin : g_pass
         assign word_p[j*ACC_W +: ACC_W] = accum_out_chained[j*ACC_W +: ACC_W];
      end else begin : g_dly
         localparam int N = OC0 - 1 - j;
         acc_t lane_p [N];

         always_ff @(posedge clk) begin
            if (en) begin
               lane_p[0] <= acc_t'(accum_out_chained[j*ACC_W +: ACC_W]);
               for (int s = 1; s < N; s++) begin
                  lane_p[s] <= lane_p[s-1];
               end
            end
         end

         assign word_p[j*ACC_W +: ACC_W] = lane_p[N-1];
      end
   end

   assign push = en & vld_p[VLD_N-1] & ~clr;
   assign pop  = out_valid & out_ready;

   sync_fifo #(
      .WIDTH (ACC_W*OC0),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .din   (word_p),
      .dout  (out_dat),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign out_valid = ~empty;
   assign fifo_room = (count <= ROOM_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (clr) begin
         overflow <= 1'b0;
      end else if (push && full && !pop) begin
         overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_accum_deskew.sv
// Randomized and directed bench for accum_deskew with a scoreboard fed by a
// step-level model of the array output and a FIFO queue.
module tb_accum_deskew;
   import accum_pkg::*;

   localparam int OC0   = 4;
   localparam int DEPTH = 8;
   localparam int W     = ACC_W * OC0;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         clr = 1'b0;
   logic         col0_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] accum_out_chained = '0;
   logic [W-1:0] out_dat;
   logic         out_valid;
   logic         fifo_room;
   logic         overflow;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   accum_deskew #(.OC0(OC0), .DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .en                (en),
      .clr               (clr),
      .col0_valid        (col0_valid),
      .accum_out_chained (accum_out_chained),
      .out_dat           (out_dat),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .fifo_room         (fifo_room),
      .overflow          (overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, req);
      end
   endtask

   // Reference: each enabled cycle is one array step; a row flagged at step n
   // is complete at step n+OC0-1, taking lane j from step n+j.
   typedef struct {
      bit           v;
      logic [W-1:0] d;
   } step_t;

   step_t        hist[$];
   logic [W-1:0] exp_q[$];
   bit           ovf_m = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      step_t        st;
      logic [W-1:0] w;
      if (!rst_n || clr) begin
         hist.delete();
         exp_q.delete();
         ovf_m = 1'b0;
      end else if (en) begin
         st.v = col0_valid;
         st.d = accum_out_chained;
         hist.push_back(st);
         if (hist.size() == OC0) begin
            if (hist[0].v) begin
               for (int j = 0; j < OC0; j++) w[j*ACC_W +: ACC_W] = hist[j].d[j*ACC_W +: ACC_W];
               if (exp_q.size() == DEPTH) ovf_m = 1'b1;
               else exp_q.push_back(w);
            end
            void'(hist.pop_front());
         end
      end
   end

   // Monitor: compares outputs every cycle and retires the head on a handshake.
   always @(negedge clk) begin
      chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
      chk("fifo_room", W'(fifo_room), W'(exp_q.size() <= DEPTH - OC0));
      chk("overflow", W'(overflow), W'(ovf_m));
      if (!rst_n) chk("reset_dat", out_dat, '0);
      if (exp_q.size() != 0) begin
         chk("out_dat", out_dat, exp_q[0]);
         if (out_ready) void'(exp_q.pop_front());
      end
   end

   logic [W-1:0] rows[$];
   bit           rowv[$];

   function automatic logic [W-1:0] rand_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic bit rdy_at(input int s, input int pct, input int from);
      return (s >= from) && ($urandom_range(99) < pct);
   endfunction

   task automatic hold_cycle(input bit rdy);
      en = 1'b0;
      col0_valid = 1'($urandom());
      accum_out_chained = rand_word();
      out_ready = rdy;
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) begin
         en = 1'b0;
         col0_valid = 1'b0;
         out_ready = rdy;
         @(posedge clk); #1;
      end
   endtask

   task automatic clr_pulse();
      clr = 1'b1;
      en = 1'b0;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   // Feeds rows diagonally: lane j at step s carries row s-j.
   task automatic launch(input int en_pct, input int rdy_pct, input int rdy_from,
                         input int stall_at, input int stall_len, input int max_steps);
      int           n;
      int           total;
      int           gaps;
      logic [W-1:0] vec;
      logic [W-1:0] r;
      n = rows.size();
      total = n + OC0 - 1;
      if (max_steps < total) total = max_steps;
      for (int s = 0; s < total; s++) begin
         if (s == stall_at)
            for (int k = 0; k < stall_len; k++) hold_cycle(rdy_at(s, rdy_pct, rdy_from));
         gaps = 0;
         while (en_pct < 100 && $urandom_range(99) >= en_pct && gaps < 5) begin
            hold_cycle(rdy_at(s, rdy_pct, rdy_from));
            gaps++;
         end
         for (int j = 0; j < OC0; j++) begin
            int idx;
            idx = s - j;
            if (idx >= 0 && idx < n) begin
               r = rows[idx];
               vec[j*ACC_W +: ACC_W] = r[j*ACC_W +: ACC_W];
            end else begin
               vec[j*ACC_W +: ACC_W] = $urandom();
            end
         end
         en = 1'b1;
         col0_valid = (s < n) ? rowv[s] : 1'b0;
         accum_out_chained = vec;
         out_ready = rdy_at(s, rdy_pct, rdy_from);
         @(posedge clk); #1;
      end
      en = 1'b0;
      col0_valid = 1'b0;
   endtask

   task automatic set_rows(input int n);
      rows.delete();
      rowv.delete();
      for (int i = 0; i < n; i++) begin
         rows.push_back(rand_word());
         rowv.push_back(1'b1);
      end
   endtask

   initial begin
      logic [W-1:0] w;
      int           c0;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      while (cyc < 10) idle(1, 1'b1);

      // Skewed row launched in cycle 10
      w = {32'd103, 32'd102, 32'd101, 32'd100};
      rows.delete(); rowv.delete();
      rows.push_back(w); rowv.push_back(1'b1);
      launch(100, 100, 0, -1, 0, 1000);
      @(negedge clk);
      chk("skew_cycle", W'(cyc), W'(14));
      chk("skew_valid", W'(out_valid), W'(1));
      chk("skew_dat", out_dat, w);
      @(posedge clk); #1;

      // Signed extremes
      w = {32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_8000, 32'hFFFF_FFFF};
      rows.delete(); rowv.delete();
      rows.push_back(w); rowv.push_back(1'b1);
      launch(100, 100, 0, -1, 0, 1000);
      @(negedge clk);
      chk("signed_dat", out_dat, w);
      @(posedge clk); #1;

      // Three-cycle stall between lane 1 and lane 2
      set_rows(1);
      w = rows[0];
      c0 = cyc;
      launch(100, 100, 0, 2, 3, 1000);
      @(negedge clk);
      chk("stall_lat", W'(cyc - c0), W'(OC0 + 3));
      chk("stall_dat", out_dat, w);
      @(posedge clk); #1;

      // Backpressure: nine rows into eight slots
      clr_pulse();
      set_rows(9);
      launch(100, 0, 0, -1, 0, 1000);
      @(negedge clk);
      chk("bp_ovf", W'(overflow), W'(1));
      chk("bp_room", W'(fifo_room), W'(0));
      @(posedge clk); #1;
      idle(8, 1'b1);
      @(negedge clk);
      chk("bp_drained", W'(out_valid), W'(0));
      @(posedge clk); #1;

      // Full FIFO with push and pop together
      clr_pulse();
      set_rows(14);
      launch(100, 100, 11, -1, 0, 1000);
      @(negedge clk);
      chk("full_ovf", W'(overflow), W'(0));
      @(posedge clk); #1;
      idle(10, 1'b1);

      // Reset with three queued and two in flight
      clr_pulse();
      set_rows(5);
      launch(100, 0, 0, -1, 0, 3 + OC0 - 1);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_valid", W'(out_valid), W'(0));
      chk("rst_dat", out_dat, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      set_rows(1);
      w = rows[0];
      launch(100, 100, 0, -1, 0, 1000);
      @(negedge clk);
      chk("rst_next", out_dat, w);
      @(posedge clk); #1;

      // Clear with the same backlog, asserted alongside en and col0_valid
      set_rows(5);
      launch(100, 0, 0, -1, 0, 3 + OC0 - 1);
      clr = 1'b1; en = 1'b1; col0_valid = 1'b1; out_ready = 1'b1;
      accum_out_chained = rand_word();
      @(posedge clk); #1;
      clr = 1'b0; en = 1'b0; col0_valid = 1'b0;
      @(negedge clk);
      chk("clr_valid", W'(out_valid), W'(0));
      @(posedge clk); #1;
      set_rows(1);
      w = rows[0];
      launch(100, 100, 0, -1, 0, 1000);
      @(negedge clk);
      chk("clr_next", out_dat, w);
      @(posedge clk); #1;

      // Randomized traffic
      for (int it = 0; it < 8; it++) begin
         int n;
         n = $urandom_range(12, 3);
         rows.delete(); rowv.delete();
         for (int i = 0; i < n; i++) begin
            rows.push_back(rand_word());
            rowv.push_back($urandom_range(99) < 70);
         end
         launch($urandom_range(100, 60), $urandom_range(100, 30), 0,
                $urandom_range(n, 0), $urandom_range(3, 0), 1000);
         idle($urandom_range(4, 0), 1'($urandom()));
      end
      idle(20, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
